// File: rtl/kpm_pkg.sv
// Shared definitions for the Karatsuba product post-processor: FSM encoding
// and the fold index width helper.
package kpm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FOLD = 2'd1,
      DONE = 2'd2
   } kpm_state_e;

   // Width of the coefficient index counter for a ring of degree d.
   function automatic int kpm_idx_w(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/coef_fold_unit.sv
// Single-coefficient fold: s = lo - hi (negacyclic), or lo + hi when
// KPM_POSTPROC_CYCLIC_EN is defined. Arithmetic wraps mod 2^N.
module coef_fold_unit #(
   parameter int N = 4
) (
   input  logic [N-1:0] lo,
   input  logic [N-1:0] hi,
   output logic [N-1:0] s
);

`ifdef KPM_POSTPROC_CYCLIC_EN
   assign s = lo + hi;
`else
   assign s = lo - hi;
`endif

endmodule

// File: rtl/kpm_dff.sv
// Enabled D flip-flop bank with asynchronous active-low clear.
module kpm_dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/karatsuba_poly_mult_postprocessor.sv
// Reduces a (2D-1)-coefficient product modulo x^D + 1 (x^D - 1 when
// KPM_POSTPROC_CYCLIC_EN is defined), one coefficient per cycle.
//
//   state | meaning
//   IDLE  | waiting for a product; in_ready high
//   FOLD  | writing r[k] for k = 0..D-1, one per cycle
//   DONE  | r complete, out_valid held until out_ready
module karatsuba_poly_mult_postprocessor
   import kpm_pkg::*;
#(
   parameter int N = 4,
   parameter int D = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [(2*D-1)*N-1:0]   p,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [D*N-1:0]         r,
   output logic                   busy
);

   localparam int KW = kpm_idx_w(D);
   localparam int PW = (2*D-1)*N;
   localparam logic [KW-1:0] K_LAST = KW'(D-1);

   kpm_state_e    state_q;
   logic [KW-1:0] k_q;
   logic          out_valid_q;
   logic          busy_q;

   logic          accept;
   logic [PW-1:0] prod_q;
   logic [N-1:0]  prod_coef [2*D];
   logic [N-1:0]  fold_lo;
   logic [N-1:0]  fold_hi;
   logic [N-1:0]  fold_s;
   logic [D-1:0]  r_wr;

   assign in_ready  = (state_q == IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   kpm_dff #(.W(PW)) u_prod_reg (
      .clk   (clk),
      .rst_n (rst),
      .en_i  (accept),
      .d_i   (p),
      .q_o   (prod_q)
   );

   // Coefficient 2D-1 does not exist; padding with zero lets the top half be
   // addressed as {1, k} so the last fold degenerates to r[D-1] = p[D-1].
   for (genvar g = 0; g < 2*D-1; g++) begin : g_coef
      assign prod_coef[g] = prod_q[g*N +: N];
   end
   assign prod_coef[2*D-1] = '0;

   assign fold_lo = prod_coef[{1'b0, k_q}];
   assign fold_hi = prod_coef[{1'b1, k_q}];

   coef_fold_unit #(.N(N)) u_fold (
      .lo (fold_lo),
      .hi (fold_hi),
      .s  (fold_s)
   );

   for (genvar g = 0; g < D; g++) begin : g_r
      localparam logic [KW-1:0] KG = KW'(g);
      assign r_wr[g] = (state_q == FOLD) && (k_q == KG);

      kpm_dff #(.W(N)) u_r_reg (
         .clk   (clk),
         .rst_n (rst),
         .en_i  (r_wr[g]),
         .d_i   (fold_s),
         .q_o   (r[g*N +: N])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= FOLD;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
               end
            end
            FOLD: begin
               if (k_q == K_LAST) begin
                  state_q     <= DONE;
                  k_q         <= '0;
                  out_valid_q <= 1'b1;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               k_q         <= '0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_karatsuba_poly_mult_postprocessor.sv
// Scoreboard bench: directed vectors on a N=4/D=4 instance, random products
// against a reference fold on an N=12/D=8 instance.
module tb_karatsuba_poly_mult_postprocessor;

   localparam int NA  = 4;
   localparam int DA  = 4;
   localparam int NB  = 12;
   localparam int DB  = 8;
   localparam int PWA = (2*DA-1)*NA;
   localparam int RWA = DA*NA;
   localparam int PWB = (2*DB-1)*NB;
   localparam int RWB = DB*NB;

   // p6..p0 = 7,6,5,4,3,2,1
   localparam logic [PWA-1:0] P1 = 28'h7654321;
   // p6..p0 = 8,2,5,1,9,0,3
   localparam logic [PWA-1:0] P3 = 28'h8251903;
   localparam logic [PWA-1:0] P_JUNK = 28'h1111111;
`ifdef KPM_POSTPROC_CYCLIC_EN
   localparam logic [RWA-1:0] EXP1 = 16'h4A86;
   localparam logic [RWA-1:0] EXP3 = 16'h1128;
   localparam logic [PWA-1:0] P_WRAP = 28'h001000F;
   localparam logic [RWA-1:0] EXP_WRAP = 16'h0000;
`else
   localparam logic [RWA-1:0] EXP1 = 16'h4CCC;
   localparam logic [RWA-1:0] EXP3 = 16'h11EE;
   localparam logic [PWA-1:0] P_WRAP = 28'h0010000;
   localparam logic [RWA-1:0] EXP_WRAP = 16'h000F;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [PWA-1:0] a_p;
   logic [RWA-1:0] a_r;
   logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [PWB-1:0] b_p;
   logic [RWB-1:0] b_r;

   karatsuba_poly_mult_postprocessor #(.N(NA), .D(DA)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .p(a_p), .out_valid(a_out_valid), .out_ready(a_out_ready), .r(a_r),
      .busy(a_busy)
   );

   karatsuba_poly_mult_postprocessor #(.N(NB), .D(DB)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .p(b_p), .out_valid(b_out_valid), .out_ready(b_out_ready), .r(b_r),
      .busy(b_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int overlap = 0;
   logic [RWA-1:0] q_a [$];
   logic [RWB-1:0] q_b [$];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [RWB-1:0] gold_b(input logic [PWB-1:0] pv);
      logic [RWB-1:0] rv;
      logic [NB-1:0]  lo, hi;
      rv = '0;
      for (int k = 0; k < DB; k++) begin
         lo = pv[k*NB +: NB];
         if (k < DB-1) hi = pv[(k+DB)*NB +: NB];
         else          hi = '0;
`ifdef KPM_POSTPROC_CYCLIC_EN
         rv[k*NB +: NB] = lo + hi;
`else
         rv[k*NB +: NB] = lo - hi;
`endif
      end
      return rv;
   endfunction

   // Monitor: compares every completed handshake against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (a_in_ready && a_out_valid) overlap++;
         if (b_in_ready && b_out_valid) overlap++;
         if (a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL a_spurious_output: got r=%h with empty scoreboard", a_r);
            end else begin
               check("a_result", a_r, q_a.pop_front());
            end
         end
         if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL b_spurious_output: got r=%h with empty scoreboard", b_r);
            end else begin
               check("b_result", b_r, q_b.pop_front());
            end
         end
      end
   end

   task automatic accept_a(output time t);
      int w = 0;
      while (w < 50) begin
         @(negedge clk);
         if (a_in_ready) break;
         w++;
      end
      if (w >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL a_accept_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      t = $time;
      #1;
   endtask

   task automatic accept_b();
      int w = 0;
      while (w < 50) begin
         @(negedge clk);
         if (b_in_ready) break;
         w++;
      end
      if (w >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL b_accept_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_a_valid(output int c);
      c = 0;
      while (c < 30) begin
         @(posedge clk); #1;
         c++;
         if (a_out_valid) break;
      end
   endtask

   initial begin
      time t0, t1, t2;
      int  c;
      logic [PWB-1:0] pv;

      a_in_valid = 0; a_out_ready = 1; a_p = '0;
      b_in_valid = 0; b_out_ready = 1; b_p = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_busy", a_busy, 0);
      check("rst_r", a_r, 0);
      check("rst_b_busy", b_busy, 0);
      rst = 1;
      #1;
      check("rst_in_ready", a_in_ready, 1);

      // Directed 1..7: out_valid appears in cycle D+1 counting the accept cycle as 0
      a_p = P1; a_in_valid = 1; q_a.push_back(EXP1);
      accept_a(t0);
      a_in_valid = 0;
      check("fold_busy", a_busy, 1);
      wait_a_valid(c);
      check("a_valid_cycle", c + 1, 5);
      @(posedge clk); #1;
      check("a_valid_drop", a_out_valid, 0);
      check("a_idle_ready", a_in_ready, 1);

      // Borrow / carry wrap
      a_p = P_WRAP; a_in_valid = 1; q_a.push_back(EXP_WRAP);
      accept_a(t0);
      a_in_valid = 0;
      wait_a_valid(c);
      @(posedge clk); #1;

      // Reset two cycles into FOLD
      a_p = P1; a_in_valid = 1; q_a.push_back(EXP1);
      accept_a(t0);
      a_in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      q_a.delete();
      #1;
      check("abort_out_valid", a_out_valid, 0);
      check("abort_busy", a_busy, 0);
      check("abort_r", a_r, 0);
      @(posedge clk); #1;
      rst = 1;
      #1;
      check("abort_in_ready", a_in_ready, 1);
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_stale", a_out_valid, 0);

      // Backpressure with an ignored second product
      a_out_ready = 0;
      a_p = P1; a_in_valid = 1; q_a.push_back(EXP1);
      accept_a(t0);
      a_in_valid = 0;
      wait_a_valid(c);
      check("bp_valid", a_out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin a_p = P_JUNK; a_in_valid = 1; end
         if (i == 3) a_in_valid = 0;
         check("bp_r_hold", a_r, EXP1);
         check("bp_in_ready", a_in_ready, 0);
         check("bp_valid_hold", a_out_valid, 1);
      end
      a_in_valid = 0;
      a_out_ready = 1;
      @(posedge clk); #1;
      check("bp_release_valid", a_out_valid, 0);
      check("bp_release_ready", a_in_ready, 1);
      repeat (8) @(posedge clk);
      #1;
      check("bp_junk_ignored", a_busy, 0);

      // Back-to-back with in_valid held high
      a_p = P1; a_in_valid = 1; q_a.push_back(EXP1);
      accept_a(t1);
      a_p = P3; q_a.push_back(EXP3);
      accept_a(t2);
      a_in_valid = 0;
      check("b2b_spacing", 128'((t2 - t1) / 10), 6);
      wait_a_valid(c);
      @(posedge clk); #1;

      // Random products on the D=8, N=12 instance
      for (int it = 0; it < 200; it++) begin
         for (int k = 0; k < 2*DB-1; k++) pv[k*NB +: NB] = NB'($urandom);
         b_p = pv; b_in_valid = 1; q_b.push_back(gold_b(pv));
         accept_b();
         b_in_valid = 0;
      end

      c = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && c < 100) begin
         @(posedge clk); c++;
      end
      #1;
      check("a_scoreboard_drained", q_a.size(), 0);
      check("b_scoreboard_drained", q_b.size(), 0);
      check("ready_valid_overlap", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/karatsuba_poly_mult_postprocessor.md
Name: karatsuba_poly_mult_postprocessor

Overview:
Consumes the full (2D-1)-coefficient product from the Karatsuba multiplier tree and reduces it modulo x^D + 1 (negacyclic ring) into D coefficients.
- Folds one coefficient per cycle under a small FSM, so a single N-bit subtractor is shared across all D coefficients.
- Presents the reduced polynomial with a valid/ready handshake to the downstream NTT/ring datapath.
- Sits directly after the multiplier's registered product output.

Parameters:
- N, 4, coefficient width in bits; arithmetic is mod 2^N.
- D, 4, ring degree and number of output coefficients; power of two, D >= 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  product word p is valid.
- in_ready  output  1  block can accept a product.
- p  input  (2*D-1)*N  product coefficients; coefficient i is at p[i*N +: N].
- out_valid  output  1  r holds a completed reduction.
- out_ready  input  1  downstream accepts r.
- r  output  D*N  reduced coefficients; coefficient i is at r[i*N +: N].
- busy  output  1  high in FOLD or DONE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, index counter k=0, product register=0, r=0, out_valid=0, busy=0. in_ready=1 once rst is high.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture p into the internal product register, clear k, go to FOLD.
  - FOLD: in_ready=0, busy=1. Each cycle computes r[k] = p[k] - p[k+D] mod 2^N for k <= D-2, and r[D-1] = p[D-1]. p[2D-1] does not exist and is treated as 0. k increments by 1. After the k=D-1 write, go to DONE.
  - DONE: out_valid=1, busy=1, r stable. On out_ready=1, go to IDLE and drop out_valid in the same edge.
- Latency: acceptance edge at cycle 0; FOLD occupies D cycles; out_valid is high from cycle D+1. Minimum throughput is one product per D+2 cycles.
- in_ready is combinational from state only (state==IDLE); it never depends on in_valid.
- in_valid while not in IDLE is ignored; input p need not be held after acceptance.
- out_ready while out_valid=0 is ignored. out_valid, once high, stays high with r unchanged until out_ready.
- r register bits update only during FOLD; r holds its last value in IDLE.
- Width rules:
  - Subtraction is N-bit two's-complement wrap; no carry or borrow is output.
  - k is $clog2(D) bits and is never compared past D-1; no wrap-around is used.
- A reset asserted in FOLD or DONE aborts immediately: the partial result is discarded and all outputs return to reset values.
- The folder makes no use of the D/2 Karatsuba split; it operates on the flat product vector.

Optional Feature:
- Macro: KPM_POSTPROC_CYCLIC_EN.
- Defined: reduction is modulo x^D - 1 (cyclic). The fold uses addition, r[k] = p[k] + p[k+D] mod 2^N, for k <= D-2. r[D-1] = p[D-1] is unchanged. Timing and handshake are identical.
- Undefined: negacyclic subtraction, as specified above.

Decomposition:
- Shared package kpm_pkg holds:
  - state encoding constants: IDLE=2'd0, FOLD=2'd1, DONE=2'd2;
  - the index-width function.
- One combinational sub-module, coef_fold_unit #(N): inputs lo, hi; output s = lo - hi, or lo + hi under the macro. It is instantiated once and shared across cycles.
- Registering stays in this module; the product register and r register use the codebase DFF primitive.

Test Plan:
- Reset with rst low mid-FOLD (after 2 cycles) -> out_valid=0, busy=0, r=0 immediately; in_ready=1 after release; no stale output afterwards.
- N=4, D=4, p coefficients 1,2,3,4,5,6,7, out_ready held 1 -> out_valid rises exactly 5 cycles after the accept edge; r = {4,12,12,12} (r3..r0); with the macro, r = {4,10,8,6}.
- Borrow wrap: p0=0, p4=1, all other coefficients 0 -> r0=15, others 0; with the macro, p0=15, p4=1 -> r0=0.
- Backpressure: out_ready=0 for 10 cycles after DONE, with in_valid pulsed using a new p -> r unchanged, in_ready=0, new p ignored; releasing out_ready returns to IDLE next edge.
- Back-to-back: two products with in_valid held high and out_ready=1 -> second accepted in the cycle after the first handshake; both results correct; accepts spaced D+2=6 cycles apart.
- D=8, N=12 random products, 200 iterations, against a golden negacyclic fold -> all r match; in_ready and out_valid never high simultaneously.
